// File: rtl/shift_pkg.sv
// Shared opcodes, FSM encoding and op classification for the shift engine.
package shift_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b001;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b010;
  localparam logic [OP_W-1:0] OP_SAR  = 3'b011;
  localparam logic [OP_W-1:0] OP_ROR  = 3'b100;
  localparam logic [OP_W-1:0] OP_ROL  = 3'b101;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b110;
  localparam logic [OP_W-1:0] OP_CLR  = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // True for the ops that run as a multi-cycle burst of one-bit steps.
  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_SAR) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shift/rotate step; non-shift ops pass data through.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] data,
  input  logic             msb_in,
  input  logic             lsb_in,
  output logic [WIDTH-1:0] next_data_c
);

  // Select the single-step result for the latched op.
  always_comb begin
    next_data_c = data;
    case (op)
      OP_SHR:  next_data_c = {msb_in, data[WIDTH-1:1]};
      OP_SHL:  next_data_c = {data[WIDTH-2:0], lsb_in};
      OP_SAR:  next_data_c = {data[WIDTH-1], data[WIDTH-1:1]};
      OP_ROR:  next_data_c = {data[0], data[WIDTH-1:1]};
      OP_ROL:  next_data_c = {data[WIDTH-2:0], data[WIDTH-1]};
      default: next_data_c = data;
    endcase
  end

endmodule

// File: rtl/shift_engine.sv
// Multi-mode shift register with command handshake and per-command burst count.
module shift_engine
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] p_out,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_data_c;
  logic             accept_c;
  logic             last_step_c;

  assign busy      = (state_q == ST_SHIFT);
  assign cmd_ready = ~busy;
  assign p_out     = data_q;
  assign done      = done_q;

  assign accept_c    = cmd_valid && cmd_ready;
  assign last_step_c = (rem_q == CNT_W'(1));

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op          (op_q),
    .data        (data_q),
    .msb_in      (msb_in),
    .lsb_in      (lsb_in),
    .next_data_c (step_data_c)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter SHIFT on a non-zero burst, leave after the last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c && is_shift_op(cmd_op) && (cmd_count != '0)) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_step_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: immediate ops at accept, one step per SHIFT cycle.
  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    op_d   = op_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          case (cmd_op)
            OP_LOAD: begin
              data_d = p_in;
              done_d = 1'b1;
            end
            OP_CLR: begin
              data_d = '0;
              done_d = 1'b1;
            end
            OP_NOP: begin
              done_d = 1'b1;
            end
            default: begin
              if (cmd_count == '0) begin
                done_d = 1'b1;
              end else begin
                op_d  = cmd_op;
                rem_d = cmd_count;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        data_d = step_data_c;
        rem_d  = rem_q - CNT_W'(1);
        done_d = last_step_c;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath and done registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      rem_q  <= '0;
      op_q   <= OP_NOP;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      rem_q  <= rem_d;
      op_q   <= op_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_shift_engine.sv
// Directed and randomized bench for shift_engine against a transaction-level model.
module tb_shift_engine;

  localparam int W  = 8;
  localparam int CW = 8;

  localparam logic [2:0] T_NOP  = 3'd0;
  localparam logic [2:0] T_SHR  = 3'd1;
  localparam logic [2:0] T_SHL  = 3'd2;
  localparam logic [2:0] T_SAR  = 3'd3;
  localparam logic [2:0] T_ROR  = 3'd4;
  localparam logic [2:0] T_ROL  = 3'd5;
  localparam logic [2:0] T_LOAD = 3'd6;
  localparam logic [2:0] T_CLR  = 3'd7;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic          msb_in;
  logic          lsb_in;
  logic [W-1:0]  p_in;
  logic [W-1:0]  p_out;
  logic          busy;
  logic          done;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_val;

  shift_engine #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .msb_in    (msb_in),
    .lsb_in    (lsb_in),
    .p_in      (p_in),
    .p_out     (p_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference one-bit step written as plain arithmetic on the value.
  function automatic logic [W-1:0] ref_step(input logic [2:0] op, input logic [W-1:0] v,
                                            input logic m, input logic l);
    logic [W-1:0] one;
    one = W'(1);
    case (op)
      T_SHR:   return (v >> 1) | (m ? (one << (W - 1)) : '0);
      T_SHL:   return (v << 1) | (l ? one : '0);
      T_SAR:   return W'($signed(v) >>> 1);
      T_ROR:   return (v >> 1) | (v << (W - 1));
      T_ROL:   return (v << 1) | (v >> (W - 1));
      default: return v;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare {busy, done, cmd_ready, p_out} against the model in one go.
  task automatic check_status(input string tag, input logic eb, input logic ed);
    check(tag, 32'({busy, done, cmd_ready, p_out}), 32'({eb, ed, ~eb, exp_val}));
  endtask

  // Issue one command from a negedge; returns at the negedge of the done cycle.
  task automatic run_cmd(input string tag, input logic [2:0] op, input int n,
                         input logic [W-1:0] p, input logic [15:0] mfill,
                         input logic [15:0] lfill, input bit hold_clr);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = CW'(n);
    p_in      = p;
    @(posedge clk);
    @(negedge clk);
    if (hold_clr) begin
      cmd_op = T_CLR;
    end else begin
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_count = CW'($urandom);
      p_in      = W'($urandom);
    end
    if (op == T_NOP || op == T_LOAD || op == T_CLR || n == 0) begin
      if (op == T_LOAD) exp_val = p;
      if (op == T_CLR)  exp_val = '0;
      check_status({tag, "_imm"}, 1'b0, 1'b1);
    end else begin
      for (int k = 0; k < n; k++) begin
        check_status({tag, "_busy"}, 1'b1, 1'b0);
        msb_in  = mfill[k];
        lsb_in  = lfill[k];
        exp_val = ref_step(op, exp_val, mfill[k], lfill[k]);
        @(posedge clk);
        @(negedge clk);
      end
      check_status({tag, "_done"}, 1'b0, 1'b1);
    end
  endtask

  task automatic idle_cycle(input string tag);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_status(tag, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] rop;
    int         rn;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = T_NOP;
    cmd_count = '0;
    msb_in    = 1'b0;
    lsb_in    = 1'b0;
    p_in      = '0;
    exp_val   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_status("reset_state", 1'b0, 1'b0);

    // LOAD, then confirm done was a single pulse
    run_cmd("load_b4", T_LOAD, 0, 8'hB4, 16'h0, 16'h0, 1'b0);
    check("load_val", 32'(p_out), 32'h00B4);
    idle_cycle("load_after");

    // SAR by 3 from 0xB4
    run_cmd("sar3", T_SAR, 3, 8'h00, 16'h0, 16'h0, 1'b0);
    check("sar3_val", 32'(p_out), 32'h00F6);

    // Serial fill on SHL and SHR
    run_cmd("load_0a", T_LOAD, 0, 8'h00, 16'h0, 16'h0, 1'b0);
    run_cmd("shl4", T_SHL, 4, 8'h00, 16'hFFFF, 16'b1101, 1'b0);
    check("shl4_val", 32'(p_out), 32'h000B);
    run_cmd("load_0b", T_LOAD, 0, 8'h00, 16'h0, 16'h0, 1'b0);
    run_cmd("shr4", T_SHR, 4, 8'h00, 16'b1011, 16'hFFFF, 1'b0);
    check("shr4_val", 32'(p_out), 32'h00B0);

    // Full rotate returns the value; one ROR after it
    run_cmd("load_b4b", T_LOAD, 0, 8'hB4, 16'h0, 16'h0, 1'b0);
    run_cmd("rol8", T_ROL, 8, 8'h00, 16'h0, 16'h0, 1'b0);
    check("rol8_val", 32'(p_out), 32'h00B4);
    run_cmd("ror1", T_ROR, 1, 8'h00, 16'h0, 16'h0, 1'b0);
    check("ror1_val", 32'(p_out), 32'h005A);

    // Zero-count shift behaves like NOP
    run_cmd("shl0", T_SHL, 0, 8'h00, 16'h0, 16'h0, 1'b0);
    check("shl0_val", 32'(p_out), 32'h005A);
    idle_cycle("shl0_after");

    // CLR held during a SHR burst is accepted only in the done cycle
    run_cmd("shr5_hold", T_SHR, 5, 8'h00, 16'h0015, 16'h0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    exp_val = '0;
    check_status("held_clr", 1'b0, 1'b1);
    check("held_clr_val", 32'(p_out), 32'h0000);
    idle_cycle("held_clr_after");

    // Reset in the 3rd cycle of a SHR burst; command held during reset is ignored
    run_cmd("load_3c", T_LOAD, 0, 8'h3C, 16'h0, 16'h0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = T_SHR;
    cmd_count = CW'(6);
    msb_in    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_status("rst_burst_c1", 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = T_LOAD;
    p_in      = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    exp_val   = '0;
    check_status("rst_abort", 1'b0, 1'b0);
    idle_cycle("rst_no_done");

    // Randomized commands, back-to-back with occasional idle gaps
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      rn  = int'($urandom_range(0, 10));
      run_cmd("rand", rop, rn, W'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) idle_cycle("rand_gap");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
